// File: rtl/bird_pkg.sv
// rtl/bird_pkg.sv - shared state encoding and default motion constants for the bird controller
package bird_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2,
        ST_GROUND = 2'd3
    } bird_state_t;

    // Shared with the position counter instantiation so both agree on range.
    localparam int BIRD_B          = 4;
    localparam int BIRD_TOP        = 13;
    localparam int BIRD_TICK_DIV   = 1_000_000;
    localparam int BIRD_RISE_TICKS = 3;
    localparam int BIRD_GRAV_START = 4;
    localparam int BIRD_GRAV_MIN   = 1;

endpackage

// File: rtl/bird_motion_ctrl_tick_gen.sv
// rtl/bird_motion_ctrl_tick_gen.sv - free-running prescaler emitting a one-cycle motion tick
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/bird_motion_ctrl.sv
// rtl/bird_motion_ctrl.sv - flap/gravity motion controller issuing inc/dec pulses to the position counter
// Define BIRD_FLAP_SYNC_EN to add a two-flop synchronizer on the flap button.
module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int b          = BIRD_B,
    parameter int TOP        = BIRD_TOP,
    parameter int TICK_DIV   = BIRD_TICK_DIV,
    parameter int RISE_TICKS = BIRD_RISE_TICKS,
    parameter int GRAV_START = BIRD_GRAV_START,
    parameter int GRAV_MIN   = BIRD_GRAV_MIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         flap,
    input  logic [b-1:0] pos,
    output logic         inc,
    output logic         dec,
    output logic         grounded,
    output logic [1:0]   state
);

    localparam int RW = $clog2(RISE_TICKS + 1);
    localparam int GW = $clog2(GRAV_START + 1);

    localparam logic [b-1:0]  TOP_V    = b'(TOP);
    localparam logic [RW-1:0] RISE_V   = RW'(RISE_TICKS);
    localparam logic [GW-1:0] GSTART_V = GW'(GRAV_START);
    localparam logic [GW-1:0] GMIN_V   = GW'(GRAV_MIN);

    bird_state_t   r_state;
    logic [RW-1:0] r_rise;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] r_intv;
    logic          r_pend;
    logic          r_inc;
    logic          r_dec;
    logic          r_grounded;
    logic          r_flap_q;

    bird_state_t   w_state_nxt;
    logic [RW-1:0] w_rise_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [GW-1:0] w_intv_nxt;
    logic          w_pend_nxt;
    logic          w_inc_nxt;
    logic          w_dec_nxt;
    logic          w_grounded_nxt;

    logic          w_flap_in;
    logic          w_flap_edge;
    logic          w_flap_req;
    logic          w_tick;
    logic          w_presc_clr;
    logic          w_below_top;
    logic [RW-1:0] w_rise_sum;
    logic [GW-1:0] w_gap_sum;

`ifdef BIRD_FLAP_SYNC_EN
    logic r_flap_s1;
    logic r_flap_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flap_s1 <= 1'b0;
            r_flap_s2 <= 1'b0;
        end else begin
            r_flap_s1 <= flap;
            r_flap_s2 <= r_flap_s1;
        end
    end

    assign w_flap_in = r_flap_s2;
`else
    assign w_flap_in = flap;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flap_q <= 1'b0;
        end else begin
            r_flap_q <= w_flap_in;
        end
    end

    assign w_flap_edge = w_flap_in & ~r_flap_q;
    // An edge landing on the tick cycle itself is served by that tick.
    assign w_flap_req  = r_pend | w_flap_edge;

    assign w_presc_clr = (r_state == ST_IDLE) || !run;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_presc_clr),
        .o_tick  (w_tick)
    );

    assign w_below_top = (pos < TOP_V);
    // A flap restarts the rise, so its tick counts as the first rise tick.
    assign w_rise_sum  = (w_flap_req ? {RW{1'b0}} : r_rise) + RW'(1);
    assign w_gap_sum   = r_gap + GW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_rise_nxt     = r_rise;
        w_gap_nxt      = r_gap;
        w_intv_nxt     = r_intv;
        w_pend_nxt     = w_flap_req;
        w_inc_nxt      = 1'b0;
        w_dec_nxt      = 1'b0;
        w_grounded_nxt = 1'b0;

        if (!run) begin
            w_state_nxt = ST_IDLE;
            w_rise_nxt  = '0;
            w_gap_nxt   = '0;
            w_intv_nxt  = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FALL;
                    w_rise_nxt  = '0;
                    w_gap_nxt   = '0;
                    w_intv_nxt  = GSTART_V;
                    w_pend_nxt  = 1'b0;
                end
                ST_RISE, ST_FALL: begin
                    if (w_tick) begin
                        w_pend_nxt = 1'b0;
                        if (w_flap_req || r_state == ST_RISE) begin
                            w_inc_nxt = w_below_top;
                            if (w_rise_sum == RISE_V) begin
                                w_state_nxt = ST_FALL;
                                w_rise_nxt  = '0;
                                w_gap_nxt   = '0;
                                w_intv_nxt  = GSTART_V;
                            end else begin
                                w_state_nxt = ST_RISE;
                                w_rise_nxt  = w_rise_sum;
                            end
                        end else if (w_gap_sum == r_intv) begin
                            if (pos == '0) begin
                                w_state_nxt = ST_GROUND;
                            end else begin
                                w_dec_nxt  = 1'b1;
                                w_gap_nxt  = '0;
                                w_intv_nxt = (r_intv > GMIN_V) ? r_intv - GW'(1) : GMIN_V;
                            end
                        end else begin
                            w_gap_nxt = w_gap_sum;
                        end
                    end
                end
                ST_GROUND: begin
                    w_pend_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end

        w_grounded_nxt = (w_state_nxt == ST_GROUND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rise     <= '0;
            r_gap      <= '0;
            r_intv     <= '0;
            r_pend     <= 1'b0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_grounded <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rise     <= w_rise_nxt;
            r_gap      <= w_gap_nxt;
            r_intv     <= w_intv_nxt;
            r_pend     <= w_pend_nxt;
            r_inc      <= w_inc_nxt;
            r_dec      <= w_dec_nxt;
            r_grounded <= w_grounded_nxt;
        end
    end

    assign inc      = r_inc;
    assign dec      = r_dec;
    assign grounded = r_grounded;
    assign state    = r_state;

endmodule
